// File: rtl/mem_1r1w_48x64_rd_frontend.sv
// Read front-end for a 48x64 1R1W masked SRAM macro.
// Fixed-latency reads with same-cycle write merge and a 2-entry response FIFO.
module mem_1r1w_48x64_rd_frontend #(
    parameter int DEPTH = 48,
    parameter int WIDTH = 64,
    parameter int AW    = 6,
    parameter int MASKW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    input  logic             wr_valid,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [MASKW-1:0] wr_mask,
    output logic [AW-1:0]    mem_R0_addr,
    output logic             mem_R0_en,
    input  logic [WIDTH-1:0] mem_R0_data,
    output logic [AW-1:0]    mem_W0_addr,
    output logic             mem_W0_en,
    output logic [WIDTH-1:0] mem_W0_data,
    output logic [MASKW-1:0] mem_W0_mask
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic             rd_in_range;
    logic             wr_in_range;
    logic             collide;
    logic             fire;
    logic             pop;
    logic             push;
    logic [2:0]       outstanding;
    logic [2:0]       avail;
    logic [WIDTH-1:0] merged;

    logic             inf_valid;
    logic             inf_err;
    logic [MASKW-1:0] inf_mask;
    logic [WIDTH-1:0] inf_wdata;

    logic [1:0]       count;
    logic [WIDTH-1:0] q0_data;
    logic [WIDTH-1:0] q1_data;
    logic             q0_err;
    logic             q1_err;

    assign rd_in_range = {1'b0, req_addr} < LIMIT;
    assign wr_in_range = {1'b0, wr_addr} < LIMIT;
    assign collide     = wr_valid && wr_in_range && (wr_addr == req_addr);

    // A pop this cycle frees a credit immediately, hence resp_ready -> req_ready.
    assign outstanding = 3'(inf_valid) + 3'(count);
    assign pop         = resp_valid && resp_ready;
    assign avail       = outstanding - 3'(pop);
    assign req_ready   = rst_n && (avail < 3'd2);
    assign fire        = req_valid && req_ready;
    assign push        = inf_valid;

    assign mem_R0_addr = req_addr;
    assign mem_R0_en   = fire && rd_in_range && rst_n;

    assign mem_W0_addr = wr_addr;
    assign mem_W0_en   = wr_valid && wr_in_range && rst_n;
    assign mem_W0_data = wr_data;
    assign mem_W0_mask = wr_mask;

    assign resp_valid  = (count != 2'd0);
    assign resp_data   = q0_data;
    assign resp_err    = q0_err;

    always_comb begin
        merged = mem_R0_data;
        for (int i = 0; i < MASKW; i++) begin
            if (inf_mask[i]) begin
                merged[8*i +: 8] = inf_wdata[8*i +: 8];
            end
        end
        if (inf_err) begin
            merged = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inf_valid <= 1'b0;
            inf_err   <= 1'b0;
            inf_mask  <= '0;
            inf_wdata <= '0;
        end else begin
            inf_valid <= fire;
            inf_err   <= fire && !rd_in_range;
            inf_mask  <= (fire && rd_in_range && collide) ? wr_mask : '0;
            if (fire) begin
                inf_wdata <= wr_data;
            end
        end
    end

    // Shift FIFO: entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 2'd0;
            q0_data <= '0;
            q1_data <= '0;
            q0_err  <= 1'b0;
            q1_err  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q0_data <= merged;
                        q0_err  <= inf_err;
                    end else begin
                        q1_data <= merged;
                        q1_err  <= inf_err;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0_data <= q1_data;
                    q0_err  <= q1_err;
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0_data <= merged;
                        q0_err  <= inf_err;
                    end else begin
                        q0_data <= q1_data;
                        q0_err  <= q1_err;
                        q1_data <= merged;
                        q1_err  <= inf_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_1r1w_48x64_rd_frontend.md
MEM_1R1W_48X64_RD_FRONTEND -- requirements
Module: mem_1r1w_48x64_rd_frontend

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 Parameters SHALL be as follows, one per line: name, default, meaning.
- DEPTH, 48, memory entries.
- WIDTH, 64, data bits.
- AW, 6, address bits.
- MASKW, 8, byte-mask bits (WIDTH/8).
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, clock; the memory R0_clk and W0_clk are tied to it externally.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, 1, read request valid.
- req_ready, out, 1, read request accepted.
- req_addr, in, AW, read address.
- resp_valid, out, 1, response valid.
- resp_ready, in, 1, response consumed.
- resp_data, out, WIDTH, read data.
- resp_err, out, 1, address was out of range.
- wr_valid, in, 1, write request; always accepted.
- wr_addr, in, AW, write address.
- wr_data, in, WIDTH, write data.
- wr_mask, in, MASKW, byte enables; bit i covers data[8i+7:8i].
- mem_R0_addr / mem_R0_en, out, AW / 1, memory read port.
- mem_R0_data, in, WIDTH, memory read data; valid the cycle after mem_R0_en.
- mem_W0_addr / mem_W0_en / mem_W0_data / mem_W0_mask, out, AW / 1 / WIDTH / MASKW, memory masked write port.

Function
REQ-004 A read fire SHALL be req_valid && req_ready.
- mem_R0_addr SHALL equal req_addr.
- mem_R0_en SHALL equal fire && (req_addr < DEPTH) && rst_n.
REQ-005 Writes SHALL pass through combinationally: mem_W0_en = wr_valid && (wr_addr < DEPTH) && rst_n, with addr, data and mask unmodified. Out-of-range writes SHALL be dropped silently.
REQ-006 Read latency SHALL be fixed.
- A fire in cycle N enqueues its response at the end of N+1.
- resp_valid is asserted no earlier than N+2.
REQ-007 Responses SHALL be held in a 2-entry FIFO and returned in request order.
- resp_data, resp_err and resp_valid SHALL come from the FIFO head and stay stable while resp_valid && !resp_ready.
REQ-008 Credit accounting:
- outstanding = in-flight (0..1) + FIFO occupancy (0..2).
- pop = resp_valid && resp_ready.
- req_ready = rst_n && (outstanding - pop < 2).
- The combinational path from resp_ready to req_ready is intentional.
- The FIFO SHALL never overflow.
REQ-009 With resp_ready held at 1, the block SHALL sustain one fire per cycle.
REQ-010 Same-cycle collision: when a fire and an in-range write to the same address occur in cycle N, the returned word SHALL be built per byte.
- Bytes with wr_mask[i]=1 take wr_data bytes captured in cycle N.
- All other bytes take mem_R0_data from N+1.
- Writes in cycle N+1 or later SHALL NOT alter that response.
REQ-011 A write in cycle N-1 or earlier SHALL be visible through memory with no forwarding.
REQ-012 A read with addr >= DEPTH SHALL not enable the memory, and SHALL return resp_data=0 and resp_err=1 with normal latency and ordering.
REQ-013 A pop and an enqueue in the same cycle SHALL keep occupancy unchanged and preserve order, including when occupancy is 1 or 2.

Reset
REQ-014 While rst_n=0 at a clock edge, the block SHALL:
- clear in-flight state, the collision capture and the FIFO;
- force resp_valid=0, resp_err=0 and resp_data=0.
REQ-015 During reset, req_ready, mem_R0_en and mem_W0_en SHALL be 0.
REQ-016 Memory data returning in the cycle after a reset SHALL be discarded.
REQ-017 The first fire after reset release SHALL be accepted in the first cycle with rst_n=1.

Verification
REQ-018 Write addr 5 = 0x0123456789ABCDEF, mask 0xFF, in cycle 0; read addr 5 at cycle 1 -> resp_data=0x0123456789ABCDEF, resp_err=0, resp_valid at cycle 3.
REQ-019 Memory holds addr 7 = 0; read addr 7 and write addr 7 = 0xFFFF_FFFF_FFFF_FFFF with mask 0x0F in the same cycle -> resp_data=0x00000000FFFFFFFF.
REQ-020 Read addr 47 then addr 48 on back-to-back cycles -> responses in order; second has resp_data=0, resp_err=1; mem_R0_en low on the second.
REQ-021 resp_ready=0 with 4 requests offered -> exactly 2 fires, req_ready=0 afterwards. Then resp_ready=1 -> all 4 responses in order, with no gap once streaming.
REQ-022 Continuous reads of addresses 0..47 with resp_ready=1 -> 48 fires in 48 consecutive cycles, data matching the preloaded pattern.
REQ-023 rst_n=0 for 1 cycle with 1 read in flight and 1 entry buffered -> resp_valid=0 afterwards, no stale response, req_ready=1 in the cycle after release.
